// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter over open-drain clock/data lines
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);
    localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk, fall, filt_flip;
    logic [FW-1:0] filt_cnt;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [8:0]    shreg, shreg_nx;
    logic          data_q, data_q_nx;
    logic [1:0]    err_q;
    logic          tmo, nack;

    assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));

    // Lines idle high, so the conditioning chain resets to the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            filt_cnt <= (clk_sync[1] == filt_clk || filt_flip) ? '0 : filt_cnt + 1'b1;
            filt_clk <= filt_flip ? clk_sync[1] : filt_clk;
            fall     <= filt_flip & filt_clk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            data_q  <= data_q_nx;
            err_q   <= err_code;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        data_q_nx  = data_q;
        nack       = 1'b0;
        tmo        = (state == SEND || state == ACK || state == WAIT_REL) && cnt == CW'(TIMEOUT_CYCLES);
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nx   = INHIBIT;
                    cnt_nx     = '0;
                    bit_cnt_nx = '0;
                    shreg_nx   = {~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                cnt_nx   = (cnt == CW'(INHIBIT_CYCLES - 1)) ? '0 : cnt + 1'b1;
                state_nx = (cnt == CW'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
            end
            REQ: begin
                state_nx  = SEND;
                cnt_nx    = cnt + 1'b1;
                data_q_nx = 1'b1;
            end
            SEND: begin
                cnt_nx = cnt + 1'b1;
                // Ones shift in from the top so the tenth edge presents the stop bit
                if (fall) begin
                    data_q_nx  = ~shreg[0];
                    shreg_nx   = {1'b1, shreg[8:1]};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    state_nx   = (bit_cnt == 4'd9) ? ACK : SEND;
                end
            end
            ACK: begin
                cnt_nx = cnt + 1'b1;
                if (fall) begin
                    nack     = dat_sync[1];
                    state_nx = dat_sync[1] ? IDLE : WAIT_REL;
                end
            end
            WAIT_REL: begin
                cnt_nx   = cnt + 1'b1;
                state_nx = (filt_clk && dat_sync[1]) ? DONE : WAIT_REL;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (tmo) state_nx = IDLE;
    end

    assign tx_ready    = state == IDLE;
    assign busy        = state != IDLE;
    assign ps2_clk_oe  = state == INHIBIT || state == REQ;
    assign ps2_data_oe = state == REQ || (state == SEND && data_q && !tmo);
    assign tx_done     = state == DONE;
    assign tx_error    = tmo | nack;
    assign err_code    = tmo ? 2'b01 : nack ? 2'b10 : err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and scoreboards the captured frame bits
module tb_ps2_host_tx;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
    logic       clk_line, data_line;

    int checks = 0, errors = 0;
    int cyc = 0, oe_cyc = 0, done_n = 0, err_n = 0, both_n = 0, acc_n = 0, req_cyc = 0, err_cyc = 0;
    logic [1:0] err_seen = 2'b00;
    logic       err_doe = 1'b0;
    bit         exp_q[$];

    ps2_host_tx #(.INHIBIT_CYCLES(100), .TIMEOUT_CYCLES(5000), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
        .err_code(err_code)
    );

    assign clk_line    = dev_clk & ~ps2_clk_oe;
    assign data_line   = dev_data & ~ps2_data_oe;
    assign ps2_clk_in  = clk_line ^ glitch;
    assign ps2_data_in = data_line;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe) oe_cyc++;
        if (ps2_clk_oe && ps2_data_oe) req_cyc = cyc;
        if (tx_done) done_n++;
        if (tx_done && tx_error) both_n++;
        if (tx_error) begin
            err_n++;
            err_cyc  = cyc;
            err_seen = err_code;
            err_doe  = ps2_data_oe;
        end
    end

    always @(posedge clk) if (rst && tx_valid && tx_ready) acc_n++;

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d, required summary before it", cyc);
        $fatal(1);
    end

    task automatic push_frame(input logic [7:0] d);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        exp_q.push_back(bit'(ones % 2 == 0));
        exp_q.push_back(1'b1);
    endtask

    task automatic phase(input bit g);
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            glitch = g && (i == 15 || i == 16);
        end
        glitch = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL accept_wait tx_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic dev_run(input bit ack, input int abort_k, input bit g, output bit aborted);
        int n = 0;
        bit e;
        aborted = 1'b0;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL dev_wait_send no start bit after %0d cycles, required SEND", n);
            return;
        end
        e = exp_q.size() > 0 ? exp_q.pop_front() : 1'b1;
        checks++;
        if (data_line !== e) begin
            errors++;
            $display("FAIL start_bit got %b required %b", data_line, e);
        end
        phase(g);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == 11 && ack) dev_data = 1'b0;
            phase(g);
            if (k == abort_k) begin
                aborted = 1'b1;
                return;
            end
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            if (k <= 10) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : ~data_line;
                checks++;
                if (data_line !== e) begin
                    errors++;
                    $display("FAIL frame_bit_%0d got %b required %b", k, data_line, e);
                end
            end
            phase(g);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_oe_busy got %b required 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        checks++;
        if ({tx_done, tx_error, err_code} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got %b required 0000", {tx_done, tx_error, err_code});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", tx_ready);
        end
    endtask

    task automatic test_send(input logic [7:0] d);
        int d0 = done_n, e0 = err_n, o0 = oe_cyc, n = 0;
        bit ab;
        push_frame(d);
        send_byte(d);
        dev_run(1'b1, 0, 1'b0, ab);
        while (done_n == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_n - d0 != 1 || err_n != e0) begin
            errors++;
            $display("FAIL send_%h_pulses done %0d err %0d required 1 0", d, done_n - d0, err_n - e0);
        end
        checks++;
        if (oe_cyc - o0 != 101) begin
            errors++;
            $display("FAIL send_%h_clk_oe_cycles got %0d required 101", d, oe_cyc - o0);
        end
        checks++;
        if ({busy, tx_ready} !== 2'b01) begin
            errors++;
            $display("FAIL send_%h_idle busy/ready got %b required 01", d, {busy, tx_ready});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL send_%h_queue got %0d left required 0", d, exp_q.size());
        end
    endtask

    task automatic test_nack;
        int d0 = done_n, e0 = err_n, n = 0;
        bit ab;
        push_frame(8'h3C);
        send_byte(8'h3C);
        dev_run(1'b0, 0, 1'b0, ab);
        while (err_n == e0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_n - e0 != 1 || done_n != d0) begin
            errors++;
            $display("FAIL nack_pulses err %0d done %0d required 1 0", err_n - e0, done_n - d0);
        end
        checks++;
        if (err_seen !== 2'b10 || err_code !== 2'b10) begin
            errors++;
            $display("FAIL nack_code got %b held %b required 10", err_seen, err_code);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL nack_idle oe/ready got %b required 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_timeout;
        int e0 = err_n, n = 0;
        send_byte(8'h55);
        while (err_n == e0 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_n - e0 != 1) begin
            errors++;
            $display("FAIL timeout_pulse got %0d required 1", err_n - e0);
        end
        checks++;
        if (err_cyc - req_cyc != 5000) begin
            errors++;
            $display("FAIL timeout_latency got %0d required 5000", err_cyc - req_cyc);
        end
        checks++;
        if (err_seen !== 2'b01 || err_doe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_code code %b data_oe %b required 01 0", err_seen, err_doe);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready got %b required 1", tx_ready);
        end
    endtask

    task automatic test_reset_mid;
        int d0, e0;
        bit ab;
        push_frame(8'h96);
        send_byte(8'h96);
        dev_run(1'b1, 4, 1'b0, ab);
        checks++;
        if (!ab || {busy, ps2_data_oe} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre aborted %b busy/data_oe %b required 1 11", ab, {busy, ps2_data_oe});
        end
        d0 = done_n;
        e0 = err_n;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async got %b required 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        exp_q.delete();
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_n != d0 || err_n != e0) begin
            errors++;
            $display("FAIL midrst_pulses done %0d err %0d required 0 0", done_n - d0, err_n - e0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_send(8'hFF);
    endtask

    task automatic test_back_to_back;
        int a0 = acc_n, d0 = done_n, e0 = err_n, n = 0;
        bit ab;
        push_frame(8'hA5);
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        fork
            dev_run(1'b1, 0, 1'b1, ab);
            begin
                repeat (20) @(negedge clk);
                tx_data = 8'h00;
                repeat (280) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        while (done_n == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (acc_n - a0 != 1) begin
            errors++;
            $display("FAIL b2b_accepts got %0d required 1", acc_n - a0);
        end
        checks++;
        if (done_n - d0 != 1 || err_n != e0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_result done %0d err %0d left %0d required 1 0 0", done_n - d0, err_n - e0, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_send(8'hED);
        test_send(8'hF4);
        test_nack;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (both_n != 0) begin
            errors++;
            $display("FAIL done_and_error_together got %0d required 0", both_n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable) over the shared open-drain PS2_CLK/PS2_DATA lines.
- Complements the existing keyboard receive path inside the object controller.
- Top level drives each PS/2 pin low when the corresponding `_oe` output is 1 and releases it (high-Z) otherwise.
- `busy` tells the receive path to ignore line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles the host holds PS2_CLK low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from request to completion (20 ms) before abort.
- FILTER_LEN, 8: consecutive identical synchronized samples required to update the filtered PS/2 clock level.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; accept occurs when tx_valid & tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_data_in  in  1  raw PS2_DATA pin level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low.
- ps2_data_oe  out  1  1 = drive PS2_DATA low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and ACK received.
- tx_error  out  1  one-cycle pulse: transfer aborted.
- err_code  out  2  valid with tx_error: 01 timeout, 10 no ACK; holds its value until the next error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, err_code=00, busy=0, bit counter=0, shift register=0. After reset release tx_ready=1.
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - The clock filter output changes only after FILTER_LEN equal consecutive samples.
  - Falling edge = filtered clock 1 -> 0, registered as a one-cycle strobe.
  - Data is used synchronized but unfiltered.
- States:
  - IDLE: oe both 0. On accept, latch {odd parity, tx_data}, go to INHIBIT and clear the counter. Odd parity: bit set so data plus parity contains an odd number of ones.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then REQ.
  - REQ: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle (this is the start bit), then SEND. The timeout counter starts here.
  - SEND: ps2_clk_oe=0, ps2_data_oe stays 1 (start bit). On falling edge k (k=1..10), present the next bit by setting ps2_data_oe = ~bit:
    - k=1..8: data bits, LSB first.
    - k=9: parity.
    - k=10: stop (1, line released).
  - After falling edge 10, go to ACK.
  - ACK: on the next falling edge (11th), sample data. Data 0 -> WAIT_REL. Data 1 -> tx_error with err_code=10, then IDLE.
  - WAIT_REL: wait until filtered clock and sync data are both 1, then DONE.
  - DONE: tx_done=1 for one cycle, then IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_REL:
  - both oe go 0 the same cycle;
  - tx_error=1 with err_code=01;
  - next state IDLE.
- tx_done and tx_error are never high together.
- tx_valid is ignored while busy; tx_data may change freely after accept.
- No falling edges are acted on in IDLE, INHIBIT or REQ.
- Reset mid-transfer releases both lines immediately (asynchronous). No pulse is generated.
- Accept-to-first-clk_oe latency: 1 cycle. REQ-to-SEND: 1 cycle.

Test Plan:
- Use INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, FILTER_LEN=4. The device model toggles the clock with a 40-cycle half-period, samples data on rising edges, and ACKs by pulling data low during the 11th low phase.
- Send 0xED -> ps2_clk_oe high exactly 101 cycles incl. REQ. Device captures start 0, bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1. Exactly one tx_done pulse; busy low after.
- Send 0xF4 -> captured bits 0,0,1,0,1,1,1,1, parity 0. tx_done pulses.
- Device never ACKs (data stays high in the 11th low phase) -> tx_error=1 for one cycle, err_code=10, both oe 0, tx_ready=1.
- Device never clocks after REQ -> tx_error exactly TIMEOUT_CYCLES after REQ, err_code=01, ps2_data_oe=0.
- Assert rst=0 during data bit 4 -> both oe 0 and busy 0 asynchronously, no pulses. Next 0xFF sends correctly: parity 1, tx_done.
- 2-cycle glitches on ps2_clk_in during SEND, plus tx_valid held high while busy -> bit sequence unchanged and only one transfer performed.
